usb_nrzi_tx_encoder: RTL

Transmit-side counterpart of the receive NRZI decoder. It accepts packet bytes over a valid/ready handshake and emits them LSB-first. It prepends SYNC, inserts a stuff bit after six consecutive 1s, NRZI-encodes the stream (0 = toggle, 1 = hold) and terminates with EOP (SE0, SE0, J). It sits between the packet/CRC layer and the line driver, and advances one bit per bit_pulse strobe.

---
 rtl/usb_nrzi_tx_encoder.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/usb_nrzi_tx_encoder.sv
// USB transmit path: byte handshake in, SYNC + bit-stuffed NRZI data + EOP out.
// One line bit is produced per bit_pulse; all line outputs are registered.
module usb_nrzi_tx_encoder #(
    parameter logic [7:0] SYNC_BYTE    = 8'h80,
    parameter int         EOP_SE0_BITS = 2
) (
    input  logic       clk,
    input  logic       nRST,
    input  logic       bit_pulse,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       line_oe,
    output logic       line_nrzi,
    output logic       line_se0,
    output logic       busy,
    output logic       tx_underrun
);

    localparam int SE0_W = $clog2(EOP_SE0_BITS + 1);

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        STUFF,
        EOP_SE0,
        EOP_J
    } state_t;

    state_t             state, state_nx;
    logic [7:0]         shifter, shifter_nx;
    logic               sync_flag, sync_nx;
    logic               cur_last, cur_last_nx;
    logic [2:0]         bit_idx, bit_idx_nx;
    logic [2:0]         ones_cnt, ones_nx;
    logic               stuff_end, stuff_end_nx;
    logic [SE0_W-1:0]   se0_cnt, se0_cnt_nx;
    logic               line_oe_nx, line_nrzi_nx, line_se0_nx;
    logic               underrun_nx;
    logic               byte_end;
    logic               pull;

    logic [7:0]         hold_data;
    logic               hold_last;
    logic               hold_full;

    // Handshake: a byte transfers on any clk where tx_valid && tx_ready;
    // tx_ready is simply "holding buffer empty", so a pull never meets a write.
    assign tx_ready = !hold_full;
    assign busy     = (state != IDLE);

    always_comb begin
        state_nx     = state;
        shifter_nx   = shifter;
        sync_nx      = sync_flag;
        cur_last_nx  = cur_last;
        bit_idx_nx   = bit_idx;
        ones_nx      = ones_cnt;
        stuff_end_nx = stuff_end;
        se0_cnt_nx   = se0_cnt;
        line_oe_nx   = line_oe;
        line_nrzi_nx = line_nrzi;
        line_se0_nx  = line_se0;
        underrun_nx  = 1'b0;
        byte_end     = 1'b0;
        pull         = 1'b0;

        if (bit_pulse) begin
            case (state)
                IDLE: begin
                    if (hold_full) begin
                        // The first SYNC bit goes out on this same strobe.
                        line_oe_nx   = 1'b1;
                        line_nrzi_nx = SYNC_BYTE[0] ? line_nrzi : ~line_nrzi;
                        ones_nx      = SYNC_BYTE[0] ? 3'd1 : 3'd0;
                        shifter_nx   = SYNC_BYTE >> 1;
                        bit_idx_nx   = 3'd1;
                        sync_nx      = 1'b1;
                        state_nx     = DATA;
                    end
                end
                DATA: begin
                    line_nrzi_nx = shifter[0] ? line_nrzi : ~line_nrzi;
                    ones_nx      = shifter[0] ? ones_cnt + 3'd1 : 3'd0;
                    shifter_nx   = shifter >> 1;
                    bit_idx_nx   = bit_idx + 3'd1;
                    if (shifter[0] && ones_cnt == 3'd5) begin
                        state_nx     = STUFF;
                        stuff_end_nx = (bit_idx == 3'd7);
                    end else if (bit_idx == 3'd7) begin
                        byte_end = 1'b1;
                    end
                end
                STUFF: begin
                    line_nrzi_nx = ~line_nrzi;
                    ones_nx      = 3'd0;
                    if (stuff_end) begin
                        byte_end = 1'b1;
                    end else begin
                        state_nx = DATA;
                    end
                end
                EOP_SE0: begin
                    if (se0_cnt < SE0_W'(EOP_SE0_BITS)) begin
                        line_se0_nx = 1'b1;
                        se0_cnt_nx  = se0_cnt + 1'b1;
                    end else begin
                        line_se0_nx  = 1'b0;
                        line_nrzi_nx = 1'b1;
                        se0_cnt_nx   = '0;
                        state_nx     = EOP_J;
                    end
                end
                EOP_J: begin
                    line_oe_nx = 1'b0;
                    state_nx   = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end

        // Byte boundary: finish the packet, chain the next byte, or underrun.
        if (byte_end) begin
            if (!sync_flag && cur_last) begin
                state_nx = EOP_SE0;
            end else if (hold_full) begin
                pull        = 1'b1;
                shifter_nx  = hold_data;
                cur_last_nx = hold_last;
                sync_nx     = 1'b0;
                bit_idx_nx  = 3'd0;
                state_nx    = DATA;
            end else begin
                underrun_nx = 1'b1;
                state_nx    = EOP_SE0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nRST) begin
            state       <= IDLE;
            shifter     <= '0;
            sync_flag   <= 1'b0;
            cur_last    <= 1'b0;
            bit_idx     <= 3'd0;
            ones_cnt    <= 3'd0;
            stuff_end   <= 1'b0;
            se0_cnt     <= '0;
            line_oe     <= 1'b0;
            line_nrzi   <= 1'b1;
            line_se0    <= 1'b0;
            tx_underrun <= 1'b0;
            hold_data   <= 8'h00;
            hold_last   <= 1'b0;
            hold_full   <= 1'b0;
        end else begin
            state       <= state_nx;
            shifter     <= shifter_nx;
            sync_flag   <= sync_nx;
            cur_last    <= cur_last_nx;
            bit_idx     <= bit_idx_nx;
            ones_cnt    <= ones_nx;
            stuff_end   <= stuff_end_nx;
            se0_cnt     <= se0_cnt_nx;
            line_oe     <= line_oe_nx;
            line_nrzi   <= line_nrzi_nx;
            line_se0    <= line_se0_nx;
            tx_underrun <= underrun_nx;
            if (tx_valid && !hold_full) begin
                hold_data <= tx_data;
                hold_last <= tx_last;
                hold_full <= 1'b1;
            end else if (pull) begin
                hold_full <= 1'b0;
            end
        end
    end

endmodule
